// File: rtl/hpdcache_sram_ecc_scrub_ctrl.sv
// ECC scrub controller: tracks SRAM reads, requests corrected writebacks on
// correctable errors, and keeps error counters, a first-error log and an irq.
module hpdcache_sram_ecc_scrub_ctrl #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sram_cs_i,
    input  logic                         sram_we_i,
    input  logic [ADDR_SIZE-1:0]         sram_addr_i,
    input  logic [NDATA*DATA_SIZE-1:0]   rdata_i,
    input  logic [NDATA-1:0]             err_cor_i,
    input  logic [NDATA-1:0]             err_unc_i,
    output logic                         wb_req_o,
    input  logic                         wb_gnt_i,
    output logic [ADDR_SIZE-1:0]         wb_addr_o,
    output logic [NDATA*DATA_SIZE-1:0]   wb_data_o,
    output logic [NDATA*DATA_SIZE-1:0]   wb_wmask_o,
    input  logic                         clear_i,
    output logic [CNT_WIDTH-1:0]         cor_cnt_o,
    output logic [CNT_WIDTH-1:0]         unc_cnt_o,
    output logic                         log_valid_o,
    output logic                         log_unc_o,
    output logic [ADDR_SIZE-1:0]         log_addr_o,
    output logic [NDATA-1:0]             log_wmask_o,
    output logic                         drop_o,
    output logic                         irq_o
);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t                       state_q, state_d;
    logic                         rd_v_q, rd_v_d;
    logic [ADDR_SIZE-1:0]         rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0]         wb_addr_q, wb_addr_d;
    logic [NDATA*DATA_SIZE-1:0]   wb_data_q, wb_data_d;
    logic [NDATA-1:0]             wb_mask_q, wb_mask_d;
    logic [CNT_WIDTH-1:0]         cor_cnt_q, cor_cnt_d;
    logic [CNT_WIDTH-1:0]         unc_cnt_q, unc_cnt_d;
    logic                         log_valid_q, log_valid_d;
    logic                         log_unc_q, log_unc_d;
    logic [ADDR_SIZE-1:0]         log_addr_q, log_addr_d;
    logic [NDATA-1:0]             log_wmask_q, log_wmask_d;
    logic                         drop_q, drop_d;
    logic                         irq_q, irq_d;

    logic unc_ev;
    logic cor_ev;
    logic cancel;

    // Error flags only mean something in the cycle after a tracked read.
    assign unc_ev = rd_v_q & (|err_unc_i);
    assign cor_ev = rd_v_q & (|err_cor_i) & ~unc_ev;
    assign cancel = sram_cs_i & sram_we_i & (sram_addr_i == wb_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_v_q      <= 1'b0;
            rd_addr_q   <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_mask_q   <= '0;
            cor_cnt_q   <= '0;
            unc_cnt_q   <= '0;
            log_valid_q <= 1'b0;
            log_unc_q   <= 1'b0;
            log_addr_q  <= '0;
            log_wmask_q <= '0;
            drop_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_v_q      <= rd_v_d;
            rd_addr_q   <= rd_addr_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_mask_q   <= wb_mask_d;
            cor_cnt_q   <= cor_cnt_d;
            unc_cnt_q   <= unc_cnt_d;
            log_valid_q <= log_valid_d;
            log_unc_q   <= log_unc_d;
            log_addr_q  <= log_addr_d;
            log_wmask_q <= log_wmask_d;
            drop_q      <= drop_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cor_ev) state_d = PEND;
            // A write by someone else to our address makes the held data stale.
            PEND: if (wb_gnt_i || cancel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_req_o   = (state_q == PEND);
        wb_addr_o  = wb_addr_q;
        wb_data_o  = wb_data_q;
        wb_wmask_o = '0;
        for (int unsigned i = 0; i < NDATA; i++) begin
            wb_wmask_o[i*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{wb_mask_q[i]}};
        end
        cor_cnt_o   = cor_cnt_q;
        unc_cnt_o   = unc_cnt_q;
        log_valid_o = log_valid_q;
        log_unc_o   = log_unc_q;
        log_addr_o  = log_addr_q;
        log_wmask_o = log_wmask_q;
        drop_o      = drop_q;
        irq_o       = irq_q;
    end

    always_comb begin
        rd_v_d    = sram_cs_i & ~sram_we_i;
        rd_addr_d = sram_addr_i;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_mask_d = wb_mask_q;
        if (state_q == IDLE && cor_ev) begin
            wb_addr_d = rd_addr_q;
            wb_data_d = rdata_i;
            wb_mask_d = err_cor_i;
        end

        cor_cnt_d   = cor_cnt_q;
        unc_cnt_d   = unc_cnt_q;
        log_valid_d = log_valid_q;
        log_unc_d   = log_unc_q;
        log_addr_d  = log_addr_q;
        log_wmask_d = log_wmask_q;
        drop_d      = drop_q;
        irq_d       = irq_q;
        if (clear_i) begin
            cor_cnt_d   = '0;
            unc_cnt_d   = '0;
            log_valid_d = 1'b0;
            log_unc_d   = 1'b0;
            log_addr_d  = '0;
            log_wmask_d = '0;
            drop_d      = 1'b0;
            irq_d       = 1'b0;
        end else begin
            if (cor_ev && cor_cnt_q != '1) cor_cnt_d = cor_cnt_q + 1'b1;
            if (unc_ev && unc_cnt_q != '1) unc_cnt_d = unc_cnt_q + 1'b1;
            if (cor_ev && state_q == PEND) drop_d = 1'b1;
            if (unc_ev) irq_d = 1'b1;
            // First event locks the log; an unc may upgrade a cor entry exactly once.
            if ((cor_ev || unc_ev) && (!log_valid_q || (!log_unc_q && unc_ev))) begin
                log_valid_d = 1'b1;
                log_unc_d   = unc_ev;
                log_addr_d  = rd_addr_q;
                log_wmask_d = err_cor_i | err_unc_i;
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_sram_ecc_scrub_ctrl.sv
// Random + directed bench for the ECC scrub controller, checked against a
// behavioural model with an expected-writeback scoreboard queue.
module tb_hpdcache_sram_ecc_scrub_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int ND = 2;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                sram_cs_i, sram_we_i;
    logic [AW-1:0]       sram_addr_i;
    logic [ND*DW-1:0]    rdata_i;
    logic [ND-1:0]       err_cor_i, err_unc_i;
    logic                wb_req_o, wb_gnt_i;
    logic [AW-1:0]       wb_addr_o;
    logic [ND*DW-1:0]    wb_data_o, wb_wmask_o;
    logic                clear_i;
    logic [CW-1:0]       cor_cnt_o, unc_cnt_o;
    logic                log_valid_o, log_unc_o;
    logic [AW-1:0]       log_addr_o;
    logic [ND-1:0]       log_wmask_o;
    logic                drop_o, irq_o;

    hpdcache_sram_ecc_scrub_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .NDATA     (ND),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sram_cs_i   (sram_cs_i),
        .sram_we_i   (sram_we_i),
        .sram_addr_i (sram_addr_i),
        .rdata_i     (rdata_i),
        .err_cor_i   (err_cor_i),
        .err_unc_i   (err_unc_i),
        .wb_req_o    (wb_req_o),
        .wb_gnt_i    (wb_gnt_i),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_wmask_o  (wb_wmask_o),
        .clear_i     (clear_i),
        .cor_cnt_o   (cor_cnt_o),
        .unc_cnt_o   (unc_cnt_o),
        .log_valid_o (log_valid_o),
        .log_unc_o   (log_unc_o),
        .log_addr_o  (log_addr_o),
        .log_wmask_o (log_wmask_o),
        .drop_o      (drop_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ND*DW-1:0] expand(input logic [ND-1:0] m);
        logic [ND*DW-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) if (m[i]) r[i*DW +: DW] = '1;
        return r;
    endfunction

    typedef struct {
        logic [AW-1:0]    addr;
        logic [ND*DW-1:0] data;
        logic [ND*DW-1:0] mask;
    } wb_t;
    wb_t exp_q[$];

    // Reference model: state as seen after each clock edge.
    bit            mon_en = 0;
    bit            m_rdv, m_pend, m_lv, m_lu, m_drop, m_irq;
    logic [AW-1:0] m_raddr, m_waddr, m_la;
    logic [ND-1:0] m_lm;
    int            m_cor, m_unc;

    always @(posedge clk) begin
        bit ev_unc, ev_cor, was_pend;
        if (rst) begin
            mon_en = 1;
            m_rdv = 0; m_raddr = '0; m_pend = 0; m_waddr = '0;
            m_cor = 0; m_unc = 0; m_lv = 0; m_lu = 0; m_la = '0; m_lm = '0;
            m_drop = 0; m_irq = 0;
            exp_q.delete();
        end else begin
            ev_unc   = m_rdv && (err_unc_i != 0);
            ev_cor   = m_rdv && (err_cor_i != 0) && !ev_unc;
            was_pend = m_pend;
            if (was_pend) begin
                if (wb_gnt_i) m_pend = 0;
                else if (sram_cs_i && sram_we_i && sram_addr_i == m_waddr) begin
                    m_pend = 0;
                    exp_q.delete();
                end
            end
            if (ev_cor && !was_pend) begin
                m_pend  = 1;
                m_waddr = m_raddr;
                exp_q.push_back('{addr: m_raddr, data: rdata_i, mask: expand(err_cor_i)});
            end
            if (clear_i) begin
                m_cor = 0; m_unc = 0; m_lv = 0; m_lu = 0; m_la = '0; m_lm = '0;
                m_drop = 0; m_irq = 0;
            end else begin
                if (ev_cor && m_cor < CMAX) m_cor++;
                if (ev_unc && m_unc < CMAX) m_unc++;
                if (ev_cor && was_pend) m_drop = 1;
                if (ev_unc) m_irq = 1;
                if ((ev_cor || ev_unc) && (!m_lv || (!m_lu && ev_unc))) begin
                    m_lv = 1; m_lu = ev_unc; m_la = m_raddr; m_lm = err_cor_i | err_unc_i;
                end
            end
            m_rdv   = sram_cs_i && !sram_we_i;
            m_raddr = sram_addr_i;
        end
    end

    // Monitor: pops the scoreboard on every granted writeback, checks status.
    always @(negedge clk) begin
        if (mon_en) begin
            wb_t e;
            chk("wb_req", wb_req_o, m_pend);
            if (wb_req_o) chk("wb_addr_hold", wb_addr_o, m_waddr);
            if (wb_req_o && wb_gnt_i) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", wb_addr_o, e.addr);
                    chk("wb_data", wb_data_o, e.data);
                    chk("wb_wmask", wb_wmask_o, e.mask);
                end
            end
            chk("cor_cnt", cor_cnt_o, m_cor);
            chk("unc_cnt", unc_cnt_o, m_unc);
            chk("log_valid", log_valid_o, m_lv);
            chk("log_unc", log_unc_o, m_lu);
            chk("log_addr", log_addr_o, m_la);
            chk("log_wmask", log_wmask_o, m_lm);
            chk("drop", drop_o, m_drop);
            chk("irq", irq_o, m_irq);
        end
    end

    task automatic cyc(input bit cs, input bit we, input logic [AW-1:0] a,
                       input logic [ND-1:0] c, input logic [ND-1:0] u,
                       input bit g, input bit cl, input bit r);
        @(posedge clk);
        #1;
        sram_cs_i = cs; sram_we_i = we; sram_addr_i = a;
        err_cor_i = c; err_unc_i = u; wb_gnt_i = g; clear_i = cl; rst = r;
        rdata_i = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, 0, 0, 0);
    endtask

    task automatic do_reset;
        cyc(0, 0, '0, '0, '0, 0, 0, 1);
        idle(1);
    endtask

    initial begin
        rst = 1; sram_cs_i = 0; sram_we_i = 0; sram_addr_i = '0; rdata_i = '0;
        err_cor_i = '0; err_unc_i = '0; wb_gnt_i = 0; clear_i = 0;
        do_reset();
        chk("rst_wb_addr", wb_addr_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_wb_wmask", wb_wmask_o, 0);

        // 1) single correctable read, grant three cycles after request rises
        cyc(1, 0, 5, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b01, '0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, '0, '0, 1, 0, 0);
        idle(2);
        chk("t1_cor_cnt", cor_cnt_o, 1);
        chk("t1_log_addr", log_addr_o, 5);

        // 2) mixed cor/unc in one row: unc wins, nothing scrubbed
        do_reset();
        cyc(1, 0, 9, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b01, 2'b10, 0, 0, 0);
        idle(2);
        chk("t2_irq", irq_o, 1);
        chk("t2_log_wmask", log_wmask_o, 2'b11);

        // 3) second cor while pending is dropped
        do_reset();
        cyc(1, 0, 3, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b10, '0, 0, 0, 0);
        cyc(1, 0, 7, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b11, '0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, '0, '0, 1, 0, 0);
        idle(2);
        chk("t3_drop", drop_o, 1);
        chk("t3_log_addr", log_addr_o, 3);

        // 4) foreign write elsewhere ignored, write to our address cancels
        do_reset();
        cyc(1, 0, 3, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b01, '0, 0, 0, 0);
        cyc(1, 1, 4, '0, '0, 0, 0, 0);
        cyc(1, 1, 3, '0, '0, 0, 0, 0);
        idle(2);
        chk("t4_req_fell", wb_req_o, 0);
        chk("t4_drop", drop_o, 0);

        // 5) saturation, then clear beats a same-cycle unc event
        do_reset();
        cyc(1, 0, 1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, AW'(i + 2), 2'b01, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b01, '0, 0, 0, 0);
        idle(1);
        chk("t5_sat", cor_cnt_o, 3);
        cyc(1, 0, 2, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, '0, 2'b01, 0, 1, 0);
        idle(1);
        chk("t5_clr_unc", unc_cnt_o, 0);
        chk("t5_clr_irq", irq_o, 0);
        cyc(0, 0, 0, '0, '0, 1, 0, 0);
        idle(1);

        // 6) reset while pending, then a normal scrub
        cyc(1, 0, 3, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b01, '0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, '0, '0, 0, 0, 1);
        idle(1);
        chk("t6_req_after_rst", wb_req_o, 0);
        cyc(1, 0, 6, '0, '0, 0, 0, 0);
        cyc(0, 0, 0, 2'b10, '0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, '0, '0, 1, 0, 0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit g, cs, we;
            logic [ND-1:0] c, u;
            g  = m_pend && ($urandom_range(0, 2) == 0);
            cs = !g && ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0;
            u  = ($urandom_range(0, 7) == 0) ? ND'($urandom) : '0;
            cyc(cs, we, AW'($urandom), c, u, g,
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, '0, m_pend, 0, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
